// File: rtl/mips_bus_master_if.sv
// Memory-side bus of mips_bus_master: word address, byte enables, read/write strobes,
// waitrequest stall and one-cycle-registered readdata from the RAM model.
interface mips_bus_master_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_master.sv
// Converts one CPU load/store at a time into a word-aligned bus access with lane steering,
// waitrequest timeout and extended load data. Optional alignment check: MIPS_BUS_ALIGN_CHECK_EN.
module mips_bus_master #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  mips_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_RESP,
    S_ERR_RESP
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(WAIT_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [15:0] wait_cnt;

  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic        misaligned;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] load_data;

  assign req_ready = (state == S_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    be_next = 4'b1111;
    wd_next = req_wdata;
    case (req_size)
      2'b00: begin
        be_next = 4'b0001 << req_addr[1:0];
        wd_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MIPS_BUS_ALIGN_CHECK_EN
  assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Right-align the addressed lane, then extend from the latched size and signedness.
  always_comb begin
    byte_shift = bus.readdata >> {lane_q, 3'b000};
    half_shift = bus.readdata >> {lane_q[1], 4'b0000};
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_data = {{16{signed_q & half_shift[15]}}, half_shift[15:0]};
      default: load_data = bus.readdata;
    endcase
  end

  // NOTE: all state and registered outputs use non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      lane_q         <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      wait_cnt       <= '0;
      bus.address    <= '0;
      bus.write      <= 1'b0;
      bus.read       <= 1'b0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lane_q         <= req_addr[1:0];
            size_q         <= req_size;
            signed_q       <= req_signed;
            wait_cnt       <= '0;
            bus.address    <= {req_addr[31:2], 2'b00};
            bus.byteenable <= be_next;
            bus.writedata  <= wd_next;
            if (misaligned) begin
              state      <= S_ERR_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              bus.write <= req_write;
              bus.read  <= ~req_write;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!bus.waitrequest) begin
            bus.write <= 1'b0;
            bus.read  <= 1'b0;
            if (bus.write) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // Abandon the access: strobe drops and no transfer is considered to have happened.
            bus.write  <= 1'b0;
            bus.read   <= 1'b0;
            state      <= S_ERR_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DATA: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP, S_ERR_RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_master.sv
// Directed bench for mips_bus_master: table of single transactions plus hand-written
// timeout, reset-abort and alignment sequences (WAIT_TIMEOUT = 4).
module tb_mips_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  localparam logic [31:0] GARBAGE = 32'h5A5A_A5A5;

  always #5 clk = ~clk;

  mips_bus_master_if bus ();

  mips_bus_master #(.WAIT_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .bus        (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from IDLE and checks every cycle through the response pulse.
  task automatic run_txn(input vec_t v, input string tag);
    check({tag, " ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_addr   = v.addr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_wdata  = v.wdata;
    step();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    for (int c = 0; c <= v.stalls; c++) begin
      bus.waitrequest = (c < v.stalls);
      check($sformatf("%s strobe c%0d", tag, c), v.wr ? bus.write : bus.read, 1);
      check($sformatf("%s other strobe c%0d", tag, c), v.wr ? bus.read : bus.write, 0);
      check($sformatf("%s address c%0d", tag, c), bus.address, v.exp_addr);
      check($sformatf("%s byteenable c%0d", tag, c), bus.byteenable, v.exp_be);
      if (v.wr) check($sformatf("%s writedata c%0d", tag, c), bus.writedata, v.exp_wd);
      check($sformatf("%s early resp c%0d", tag, c), resp_valid, 0);
      step();
    end
    bus.waitrequest = 1'b0;
    if (!v.wr) begin
      check({tag, " data read low"}, bus.read, 0);
      check({tag, " data no resp"}, resp_valid, 0);
      bus.readdata = v.rdata;
      step();
      bus.readdata = GARBAGE;
    end else begin
      check({tag, " resp write low"}, bus.write, 0);
    end
    check({tag, " resp_valid"}, resp_valid, 1);
    check({tag, " resp_error"}, resp_error, 0);
    check({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
    step();
    check({tag, " pulse end"}, resp_valid, 0);
    check({tag, " rdata cleared"}, resp_rdata, 0);
    check({tag, " back idle"}, req_ready, 1);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    addr          size   sgn   wdata          rdata          st exp_addr      be       exp_wd         exp_rdata
    vecs[0] = '{1'b1, 32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,         0, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'h0,         32'h80FF_7F01, 0, 32'h0000_0010, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[2] = '{1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,         32'h80FF_7F01, 0, 32'h0000_0010, 4'b1000, 32'h0,         32'h0000_0080};
    vecs[3] = '{1'b1, 32'h0000_0002, 2'b01, 1'b0, 32'hABCD_1234, 32'h0,         2, 32'h0000_0000, 4'b1100, 32'h1234_1234, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0000, 2'b01, 1'b1, 32'h0,         32'h1234_8001, 1, 32'h0000_0000, 4'b0011, 32'h0,         32'hFFFF_8001};
    vecs[5] = '{1'b0, 32'h0000_0006, 2'b01, 1'b0, 32'h0,         32'h8001_7FFF, 0, 32'h0000_0004, 4'b1100, 32'h0,         32'h0000_8001};
    vecs[6] = '{1'b1, 32'h0000_0101, 2'b00, 1'b0, 32'h0000_00A5, 32'h0,         1, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0022, 2'b00, 1'b1, 32'h0,         32'h11AA_3344, 0, 32'h0000_0020, 4'b0100, 32'h0,         32'hFFFF_FFAA};
    vecs[8] = '{1'b0, 32'h0000_0040, 2'b11, 1'b1, 32'h0,         32'hCAFE_F00D, 0, 32'h0000_0040, 4'b1111, 32'h0,         32'hCAFE_F00D};
    vecs[9] = '{1'b0, 32'h0000_0000, 2'b00, 1'b1, 32'h0,         32'h0000_007F, 0, 32'h0000_0000, 4'b0001, 32'h0,         32'h0000_007F};

    reset           = 1'b1;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_addr        = '0;
    req_size        = '0;
    req_signed      = 1'b0;
    req_wdata       = '0;
    bus.waitrequest = 1'b0;
    bus.readdata    = GARBAGE;
    step();

    check("reset req_ready", req_ready, 1);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_error", resp_error, 0);
    check("reset resp_rdata", resp_rdata, 0);
    check("reset address", bus.address, 0);
    check("reset read", bus.read, 0);
    check("reset write", bus.write, 0);
    check("reset writedata", bus.writedata, 0);
    check("reset byteenable", bus.byteenable, 0);
    reset = 1'b0;
    step();

    // Back-to-back: each run_txn starts in the IDLE cycle the previous one ended in.
    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Misaligned word / halfword loads.
`ifdef MIPS_BUS_ALIGN_CHECK_EN
    begin
      logic [31:0] mis_addr[2];
      logic [1:0]  mis_size[2];
      mis_addr[0] = 32'h0000_0002; mis_size[0] = 2'b10;
      mis_addr[1] = 32'h0000_0003; mis_size[1] = 2'b01;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("mis%0d ready", i), req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = mis_addr[i];
        req_size  = mis_size[i];
        step();
        req_valid = 1'b0;
        check($sformatf("mis%0d no read", i), bus.read, 0);
        check($sformatf("mis%0d resp_valid", i), resp_valid, 1);
        check($sformatf("mis%0d resp_error", i), resp_error, 1);
        check($sformatf("mis%0d resp_rdata", i), resp_rdata, 0);
        step();
        check($sformatf("mis%0d pulse end", i), resp_valid, 0);
        check($sformatf("mis%0d idle", i), req_ready, 1);
      end
    end
`else
    begin
      vec_t m;
      m = '{1'b0, 32'h0000_0002, 2'b10, 1'b0, 32'h0, 32'h0102_0304, 0, 32'h0000_0000, 4'b1111, 32'h0, 32'h0102_0304};
      run_txn(m, "unal_word");
      m = '{1'b0, 32'h0000_0003, 2'b01, 1'b0, 32'h0, 32'hBEEF_1111, 0, 32'h0000_0000, 4'b1100, 32'h0, 32'h0000_BEEF};
      run_txn(m, "unal_half");
    end
`endif

    // Timeout: waitrequest stuck high, a second request held pending must be ignored.
    req_valid       = 1'b1;
    req_write       = 1'b0;
    req_addr        = 32'h0000_0020;
    req_size        = 2'b10;
    bus.waitrequest = 1'b1;
    step();
    req_addr = 32'h0000_0999;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("to read c%0d", c), bus.read, 1);
      check($sformatf("to address c%0d", c), bus.address, 32'h0000_0020);
      check($sformatf("to not ready c%0d", c), req_ready, 0);
      check($sformatf("to no resp c%0d", c), resp_valid, 0);
      step();
    end
    req_valid = 1'b0;
    check("to read dropped", bus.read, 0);
    check("to resp_valid", resp_valid, 1);
    check("to resp_error", resp_error, 1);
    check("to resp_rdata", resp_rdata, 0);
    step();
    bus.waitrequest = 1'b0;
    check("to pulse end", resp_valid, 0);
    check("to error cleared", resp_error, 0);
    check("to idle", req_ready, 1);
    check("to no new read", bus.read, 0);

    // Reset during a stalled REQ drops the strobe asynchronously.
    req_valid       = 1'b1;
    req_write       = 1'b1;
    req_addr        = 32'h0000_0030;
    req_size        = 2'b10;
    req_wdata       = 32'h1357_9BDF;
    bus.waitrequest = 1'b1;
    step();
    req_valid = 1'b0;
    check("rreq write before", bus.write, 1);
    reset = 1'b1;
    #1;
    check("rreq write async", bus.write, 0);
    check("rreq byteenable", bus.byteenable, 0);
    check("rreq address", bus.address, 0);
    check("rreq ready", req_ready, 1);
    step();
    reset           = 1'b0;
    bus.waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rreq no resp c%0d", c), resp_valid, 0);
      check($sformatf("rreq no write c%0d", c), bus.write, 0);
    end

    // Reset during DATA: no response pulse afterwards.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0031;
    req_size  = 2'b00;
    step();
    req_valid = 1'b0;
    check("rdata read c1", bus.read, 1);
    step();
    check("rdata read low in DATA", bus.read, 0);
    check("rdata be in DATA", bus.byteenable, 4'b0010);
    bus.readdata = 32'h0000_7700;
    reset = 1'b1;
    #1;
    check("rdata be async", bus.byteenable, 0);
    check("rdata read async", bus.read, 0);
    check("rdata resp async", resp_valid, 0);
    check("rdata ready", req_ready, 1);
    step();
    reset        = 1'b0;
    bus.readdata = GARBAGE;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rdata no resp c%0d", c), resp_valid, 0);
      check($sformatf("rdata rdata zero c%0d", c), resp_rdata, 0);
    end
    check("rdata idle", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
